rc4_prga_decrypt: RTL
=====================

# rc4_prga_decrypt

Keystream-generation and decryption stage of the RC4 decryption circuit. It sits directly downstream of the key-scheduling (swap) state machine. Once that block has finished permuting S memory, this block runs the RC4 pseudo-random generation algorithm over S. Each keystream byte is XORed with the next encrypted-message ROM byte and the plaintext is written to the decrypted-message RAM. It signals `finish` when all bytes are written.

## Interface
- `ADDR_W`, 5: address width of the encrypted ROM and decrypted RAM.
- `MSG_LEN`, 32: number of message bytes to decrypt; legal range 1..2**ADDR_W.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `start_machine`  in  1  level; sampled only in IDLE. Driven by the swap stage's `finish`.
- `s_q`  in  8  S memory read data.
- `s_address`  out  8  S memory address.
- `s_data`  out  8  S memory write data.
- `s_wren`  out  1  S memory write enable.
- `rom_address`  out  ADDR_W  encrypted ROM address (= k).
- `rom_q`  in  8  encrypted ROM read data.
- `ram_address`  out  ADDR_W  decrypted RAM address (= k).
- `ram_data`  out  8  plaintext byte.
- `ram_wren`  out  1  decrypted RAM write enable.
- `finish`  out  1  high, and held, once all MSG_LEN bytes are written.

## Operation
- Algorithm: i=0, j=0. For k=0..MSG_LEN-1:
  - i=i+1; j=j+S[i]; swap S[i],S[j].
  - f=S[(S[i]+S[j]) mod 256]; RAM[k]=f XOR ROM[k].
- All of i, j, and the f-address sum are 8-bit, wrap mod 256. k is ADDR_W bits.
- Memory model: address and write enable are sampled on a clock edge. Read data for an address driven in cycle N is valid on `s_q`/`rom_q` in cycle N+1. A write is committed at the end of the cycle in which wren is high.
- Internal registers: i, j, k, si, sj, out_byte. All are cleared by reset and on start acceptance.
- States, one cycle each unless noted:
  - IDLE: waits. If `start_machine`=1, clear i/j/k and go to INC_I.
  - INC_I: i<=i+1.
  - READ_SI: s_address=i.
  - LATCH_SI: si<=s_q; j<=j+s_q.
  - READ_SJ: s_address=j.
  - LATCH_SJ: sj<=s_q.
  - WRITE_SJ: s_address=j, s_data=si, s_wren=1.
  - WRITE_SI: s_address=i, s_data=sj, s_wren=1.
  - READ_F: s_address=si+sj.
  - LATCH_F: out_byte<=s_q XOR rom_q.
  - WRITE_OUT: ram_data=out_byte, ram_wren=1. If k==MSG_LEN-1, go to DONE; else k<=k+1 and go to INC_I.
  - DONE: finish=1. Stays in DONE until reset; `start_machine` is ignored.
- Default decodes:
  - s_address=i outside the states listed above.
  - s_data=0 outside the write states.
  - s_wren=0 and ram_wren=0 outside their write states.
  - rom_address and ram_address are always k.
- i==j: both swap writes target the same word, and the final value equals the original. No special casing is needed.

## Timing
- Reset values: state IDLE; s_address=0, s_data=0, s_wren=0, rom_address=0, ram_address=0, ram_data=0, ram_wren=0, finish=0.
- Outputs take these values in the cycle after the reset edge.
- Reset mid-operation: abort immediately and write nothing further. S and RAM may be partially updated; a new start restarts from i=j=k=0.
- Cycle 0 is the edge that samples `start_machine`. INC_I occurs in cycle 1.
- Each byte takes exactly 10 cycles. Byte k's ram_wren pulse is in cycle 10(k+1).
- finish rises in cycle 10·MSG_LEN+1; 321 for the default.
- ram_wren and s_wren are single-cycle pulses; there are never two consecutive S writes to different bytes outside WRITE_SJ→WRITE_SI.
- `start_machine` held high after DONE has no effect.

## Test plan
- S preloaded S[x]=x, ROM all 0x00, MSG_LEN=4, start pulse:
  - RAM writes at cycles 10/20/30/40 = 0x02, 0x05, 0x07, 0x0D.
  - finish high at cycle 41.
  - Final S: S[2]=3, S[3]=5, S[4]=9, S[5]=2, S[9]=4.
- Same S, ROM = 0xFF each byte → RAM = 0xFD, 0xFA, 0xF8, 0xF2. Confirms the XOR path and that rom_address tracks k.
- S all 0x80, ROM 0x00, MSG_LEN=2:
  - j wraps 0x80→0x00; s_address in WRITE_SJ is 0x80 then 0x00.
  - RAM = 0x80, 0x80.
- Assert reset during byte 1's WRITE_SJ:
  - Next cycle s_wren=0, finish=0, state IDLE, no further RAM writes.
  - Re-preload S and restart; the results of test 1 are reproduced.
- Hold start_machine high through DONE:
  - finish stays 1 and no further s_wren/ram_wren pulses occur.
  - With MSG_LEN=32 default, finish rises at cycle 321 and exactly 32 ram_wren pulses are seen.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decryption stage.
// Runs the RC4 PRGA over the permuted S memory. Each keystream byte is
// XORed with the matching encrypted ROM byte, and the plaintext is written
// to the decrypted RAM. Every output is a register that is loaded on the
// edge that enters the state using it, so the memories see clean values.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | wait for start_machine
// INC_I     | i <= i+1
// READ_SI   | drive s_address = i
// LATCH_SI  | si <= S[i], j <= j+S[i]
// READ_SJ   | drive s_address = j
// LATCH_SJ  | sj <= S[j]
// WRITE_SJ  | S[j] <= si
// WRITE_SI  | S[i] <= sj
// READ_F    | drive s_address = si+sj
// LATCH_F   | out_byte <= S[si+sj] ^ ROM[k]
// WRITE_OUT | RAM[k] <= out_byte, advance k or finish
// DONE      | finish held until reset
module rc4_prga_decrypt #(
  parameter int ADDR_W  = 5,
  parameter int MSG_LEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_machine,
  input  logic [7:0]        s_q,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] K_LAST = (ADDR_W)'(MSG_LEN - 1);
  localparam logic [ADDR_W-1:0] K_ONE  = (ADDR_W)'(1);

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    READ_SI,
    LATCH_SI,
    READ_SJ,
    LATCH_SJ,
    WRITE_SJ,
    WRITE_SI,
    READ_F,
    LATCH_F,
    WRITE_OUT,
    DONE
  } state_t;

  state_t            state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [7:0]        out_byte;
  logic [ADDR_W-1:0] k;

  assign rom_address = k;
  assign ram_address = k;
  assign ram_data    = out_byte;

  // Sequencer: next state plus the registered memory controls for that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      out_byte  <= '0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      ram_wren  <= 1'b0;
      finish    <= 1'b0;
    end else begin
      // Idle bus: S address parked on i, no writes.
      s_wren    <= 1'b0;
      ram_wren  <= 1'b0;
      s_data    <= '0;
      s_address <= i;
      case (state)
        IDLE: begin
          if (start_machine) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            out_byte  <= '0;
            s_address <= '0;
            state     <= INC_I;
          end
        end
        INC_I: begin
          i         <= i + 8'd1;
          s_address <= i + 8'd1;
          state     <= READ_SI;
        end
        READ_SI: state <= LATCH_SI;
        LATCH_SI: begin
          si        <= s_q;
          j         <= j + s_q;
          s_address <= j + s_q;
          state     <= READ_SJ;
        end
        READ_SJ: state <= LATCH_SJ;
        LATCH_SJ: begin
          sj        <= s_q;
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= WRITE_SJ;
        end
        WRITE_SJ: begin
          // When i == j this rewrites the same word with its original value.
          s_address <= i;
          s_data    <= sj;
          s_wren    <= 1'b1;
          state     <= WRITE_SI;
        end
        WRITE_SI: begin
          s_address <= si + sj;
          state     <= READ_F;
        end
        READ_F: state <= LATCH_F;
        LATCH_F: begin
          out_byte <= s_q ^ rom_q;
          ram_wren <= 1'b1;
          state    <= WRITE_OUT;
        end
        WRITE_OUT: begin
          if (k == K_LAST) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            k     <= k + K_ONE;
            state <= INC_I;
          end
        end
        DONE: finish <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
